// File: rtl/req5_arbiter.sv
// Five-requester arbiter: fixed priority (or rotating priority when ARB5_ROUND_ROBIN_EN
// is defined) with ownership hold, release gap, hold timeout and post-timeout masking.
module req5_arbiter #(
    parameter int HOLD_MAX  = 255,
    parameter int CNT_WIDTH = 8
) (
    input  logic       C,
    input  logic       R,
    input  logic [4:0] REQ,
    output logic [4:0] GNT,
    output logic [2:0] GNT_ID,
    output logic       BUSY,
    output logic       TIMEOUT,
    output logic [1:0] dbg_state
);

    // Handshake: a requester holds REQ high to ask for and keep the resource; GNT is
    // the registered answer and dropping REQ is the only way to hand it back early.

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN  = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] HOLD_LIM = CNT_WIDTH'(HOLD_MAX);
    localparam logic [2:0]           NO_ID    = 3'd7;

    state_t               state_q, state_d;
    logic [4:0]           gnt_q, gnt_d;
    logic [2:0]           gnt_id_q, gnt_id_d;
    logic                 busy_q, busy_d;
    logic                 timeout_q, timeout_d;
    logic [4:0]           mask_q, mask_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [4:0]           cand;
    logic [2:0]           start;
    logic [2:0]           win;
    logic                 owner_req;

`ifdef ARB5_ROUND_ROBIN_EN
    logic [2:0] ptr_q, ptr_d;
    assign start = ptr_q;
`else
    assign start = 3'd0;
`endif

    // First requester in cand, searching upward from start and wrapping 4 -> 0.
    function automatic logic [2:0] pick(input logic [4:0] c, input logic [2:0] s);
        logic [3:0] idx;
        logic       found;
        pick  = NO_ID;
        found = 1'b0;
        for (int k = 0; k < 5; k++) begin
            idx = {1'b0, s} + 4'(k);
            if (idx > 4'd4) idx = idx - 4'd5;
            if (!found && c[idx[2:0]]) begin
                pick  = idx[2:0];
                found = 1'b1;
            end
        end
    endfunction

    assign cand      = REQ & ~mask_q;
    assign win       = pick(cand, start);
    assign owner_req = |(REQ & gnt_q);

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        gnt_id_d  = gnt_id_q;
        timeout_d = 1'b0;
        mask_d    = mask_q & REQ;
        cnt_d     = cnt_q;
`ifdef ARB5_ROUND_ROBIN_EN
        ptr_d     = ptr_q;
`endif
        case (state_q)
            IDLE: begin
                if (|cand) begin
                    gnt_d    = 5'd1 << win;
                    gnt_id_d = win;
                    cnt_d    = '0;
                    state_d  = OWN;
`ifdef ARB5_ROUND_ROBIN_EN
                    ptr_d    = (win == 3'd4) ? 3'd0 : win + 3'd1;
`endif
                end
            end
            OWN: begin
                // Release is checked first so a release coinciding with the limit
                // never masks the requester or pulses TIMEOUT.
                if (!owner_req) begin
                    gnt_d    = '0;
                    gnt_id_d = NO_ID;
                    state_d  = GAP;
                end else if (HOLD_MAX != 0 && cnt_q == HOLD_LIM) begin
                    gnt_d     = '0;
                    gnt_id_d  = NO_ID;
                    timeout_d = 1'b1;
                    mask_d    = mask_d | gnt_q;
                    state_d   = GAP;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                end
            end
            GAP: begin
                state_d = IDLE;
            end
            default: begin
                gnt_d    = '0;
                gnt_id_d = NO_ID;
                state_d  = IDLE;
            end
        endcase
        busy_d = |gnt_d;
    end

    always_ff @(posedge C) begin
        if (R) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            gnt_id_q  <= NO_ID;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
            mask_q    <= '0;
            cnt_q     <= '0;
`ifdef ARB5_ROUND_ROBIN_EN
            ptr_q     <= 3'd0;
`endif
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            gnt_id_q  <= gnt_id_d;
            busy_q    <= busy_d;
            timeout_q <= timeout_d;
            mask_q    <= mask_d;
            cnt_q     <= cnt_d;
`ifdef ARB5_ROUND_ROBIN_EN
            ptr_q     <= ptr_d;
`endif
        end
    end

    assign GNT       = gnt_q;
    assign GNT_ID    = gnt_id_q;
    assign BUSY      = busy_q;
    assign TIMEOUT   = timeout_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_req5_arbiter.sv
// Directed bench for req5_arbiter (HOLD_MAX = 4); expectations follow ARB5_ROUND_ROBIN_EN.
module tb_req5_arbiter;

  logic       clk;
  logic       rst;
  logic [4:0] req;
  logic [4:0] gnt;
  logic [2:0] gnt_id;
  logic       busy;
  logic       timeout;
  logic [1:0] dbg_state;

  int checks = 0;
  int fails  = 0;
  logic [9:0] exp_q[$];

  req5_arbiter #(.HOLD_MAX(4), .CNT_WIDTH(8)) dut (
    .C(clk), .R(rst), .REQ(req), .GNT(gnt), .GNT_ID(gnt_id),
    .BUSY(busy), .TIMEOUT(timeout), .dbg_state(dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [2:0] id_of(input logic [4:0] g);
    id_of = 3'd7;
    for (int i = 0; i < 5; i++) if (g[i]) id_of = 3'(i);
  endfunction

  function automatic logic [4:0] onehot(input int i);
    logic [4:0] one;
    one = 5'd1;
    onehot = one << i;
  endfunction

  // Drive one cycle, push the outputs expected after the edge, then pop and compare.
  task automatic step(input logic r, input logic [4:0] rq, input logic [4:0] eg,
                      input logic et, input string tag);
    logic [9:0] obs;
    logic [9:0] exp;
    @(negedge clk);
    rst = r;
    req = rq;
    exp_q.push_back({eg, id_of(eg), |eg, et});
    @(posedge clk);
    #1;
    obs = {gnt, gnt_id, busy, timeout};
    exp = exp_q.pop_front();
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed gnt/id/busy/to=%b required %b", tag, obs, exp);
    end
  endtask

  initial begin
    int o;
    rst = 1'b1;
    req = 5'b00000;

    // Reset held with all requests high
    for (int i = 0; i < 3; i++) step(1, 5'b11111, 5'b00000, 0, "reset_hold");
    step(0, 5'b11111, 5'b00001, 0, "first_grant");
    step(0, 5'b00000, 5'b00000, 0, "first_release");
    step(0, 5'b00000, 5'b00000, 0, "first_gap");

    // Priority decode
    step(1, 5'b00000, 5'b00000, 0, "prio_reset");
    step(0, 5'b10000, 5'b10000, 0, "prio_req4_only");
    step(0, 5'b00000, 5'b00000, 0, "prio_rel4");
    step(0, 5'b00000, 5'b00000, 0, "prio_gap4");
    step(0, 5'b11000, 5'b01000, 0, "prio_3_over_4");

    // Release and break-before-make gap
    step(1, 5'b00000, 5'b00000, 0, "rel_reset");
    step(0, 5'b00100, 5'b00100, 0, "rel_grant2");
    step(0, 5'b10100, 5'b00100, 0, "rel_hold2a");
    step(0, 5'b10100, 5'b00100, 0, "rel_hold2b");
    step(0, 5'b10000, 5'b00000, 0, "rel_drop2");
    step(0, 5'b10000, 5'b00000, 0, "rel_gap");
    step(0, 5'b10000, 5'b10000, 0, "rel_grant4");

    // Hold timeout, masking and unmasking
    step(1, 5'b00000, 5'b00000, 0, "to_reset");
    step(0, 5'b00011, 5'b00001, 0, "to_grant0");
    for (int i = 0; i < 4; i++) step(0, 5'b00011, 5'b00001, 0, "to_hold0");
    step(0, 5'b00011, 5'b00000, 1, "to_revoke");
    step(0, 5'b00011, 5'b00000, 0, "to_gap");
    step(0, 5'b00011, 5'b00010, 0, "to_grant1_masked0");
    step(0, 5'b00001, 5'b00000, 0, "to_rel1");
    step(0, 5'b00001, 5'b00000, 0, "to_gap1");
    step(0, 5'b00001, 5'b00000, 0, "to_still_masked");
    step(0, 5'b00000, 5'b00000, 0, "to_drop0");
    step(0, 5'b00001, 5'b00001, 0, "to_regrant0");

    // Rotation with all requesters active
    step(1, 5'b00000, 5'b00000, 0, "rr_reset");
    for (int g = 0; g < 6; g++) begin
`ifdef ARB5_ROUND_ROBIN_EN
      o = g % 5;
`else
      o = 0;
`endif
      step(0, 5'b11111, onehot(o), 0, $sformatf("rr_grant%0d", g));
      step(0, 5'b11111, onehot(o), 0, $sformatf("rr_hold%0d", g));
      step(0, 5'b11111 & ~onehot(o), 5'b00000, 0, $sformatf("rr_rel%0d", g));
      step(0, 5'b11111, 5'b00000, 0, $sformatf("rr_gap%0d", g));
    end

    // Reset in the middle of an ownership, with a mask set
    step(1, 5'b00000, 5'b00000, 0, "mid_reset0");
    step(0, 5'b00001, 5'b00001, 0, "mid_grant0");
    for (int i = 0; i < 4; i++) step(0, 5'b00001, 5'b00001, 0, "mid_hold0");
    step(0, 5'b00001, 5'b00000, 1, "mid_revoke0");
    step(0, 5'b00101, 5'b00000, 0, "mid_gap");
    step(0, 5'b00101, 5'b00100, 0, "mid_grant2_masked0");
    for (int i = 0; i < 3; i++) step(0, 5'b00101, 5'b00100, 0, "mid_hold2");
    step(1, 5'b00101, 5'b00000, 0, "mid_reset_out");
    step(0, 5'b00101, 5'b00001, 0, "mid_mask_cleared");

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
